// File: rtl/mul_unit_if.sv
// Request/result bundle for mul_unit: operation request in, status and result out.
interface mul_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] acc;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic [1:0]       flags;

  modport master (
    output start, mode, a, b, acc,
    input  busy, done, result_lo, result_hi, flags
  );

  modport slave (
    input  start, mode, a, b, acc,
    output busy, done, result_lo, result_hi, flags
  );
endinterface

// File: rtl/mul_unit.sv
// Sequential radix-2 shift-add multiplier: MUL, MLA, UMULL, SMULL.
// Fixed latency: IDLE -> CALC (WIDTH steps) -> FIX -> DONE -> IDLE.
module mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  mul_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] M_MUL   = 2'b00;
  localparam logic [1:0] M_MLA   = 2'b01;
  localparam logic [1:0] M_UMULL = 2'b10;
  localparam logic [1:0] M_SMULL = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [1:0]         r_mode;
  logic               r_sign;
  logic [WIDTH-1:0]   r_a, r_b, r_acc;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_lo, r_hi;
  logic [1:0]         r_flags;

  logic               w_smull;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic               w_last;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_neg;
  logic [WIDTH-1:0]   w_lo, w_hi;
  logic [1:0]         w_flags;

  // Operand conditioning: SMULL works on magnitudes; |MIN| stays exact as unsigned.
  assign w_smull = (bus.mode == M_SMULL);
  assign w_abs_a = (w_smull && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
  assign w_abs_b = (w_smull && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;
  assign w_last  = (r_cnt == CW'(WIDTH-1));

  // One shift-add step: add multiplicand into the high half, shift the whole product right.
  assign w_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, (r_b[0] ? r_a : '0)};
  assign w_neg   = ~r_prod + 1'b1;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_CALC;
      S_CALC:  if (w_last)    w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand latch and iterative product.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_mode <= M_MUL;
      r_sign <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_prod <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_cnt  <= '0;
          r_mode <= bus.mode;
          r_sign <= w_smull & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          r_a    <= w_abs_a;
          r_b    <= w_abs_b;
          r_acc  <= bus.acc;
          r_prod <= '0;
        end
        S_CALC: begin
          r_prod <= {w_sum, r_prod[WIDTH-1:1]};
          r_b    <= r_b >> 1;
          r_cnt  <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Final result shaping per mode, plus {N,Z}.
  always_comb begin
    w_lo    = r_prod[WIDTH-1:0];
    w_hi    = '0;
    w_flags = 2'b00;
    case (r_mode)
      M_MUL: w_lo = r_prod[WIDTH-1:0];
      M_MLA: w_lo = r_prod[WIDTH-1:0] + r_acc;
      M_UMULL: {w_hi, w_lo} = r_prod;
      M_SMULL: {w_hi, w_lo} = r_sign ? w_neg : r_prod;
      default: ;
    endcase
    if (r_mode[1]) w_flags = {w_hi[WIDTH-1], ({w_hi, w_lo} == '0)};
    else           w_flags = {w_lo[WIDTH-1], (w_lo == '0)};
  end

  // Result registers load on the FIX->DONE edge and hold until the next FIX.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lo    <= '0;
      r_hi    <= '0;
      r_flags <= 2'b00;
    end else if (r_state == S_FIX) begin
      r_lo    <= w_lo;
      r_hi    <= w_hi;
      r_flags <= w_flags;
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.result_lo = r_lo;
  assign bus.result_hi = r_hi;
  assign bus.flags     = r_flags;
endmodule

// File: tb/tb_mul_unit.sv
// Bench for mul_unit (WIDTH=32): directed cases plus randomized ops vs. an arithmetic model.
module tb_mul_unit;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  logic [31:0] prev_lo, prev_hi;

  mul_unit_if #(.WIDTH(32)) bus ();

  mul_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic on the operands.
  function automatic void model(input logic [1:0] m, input logic [31:0] av, input logic [31:0] bv,
                                input logic [31:0] accv, output logic [31:0] lo,
                                output logic [31:0] hi, output logic [1:0] fl);
    logic signed [63:0] sp;
    logic [63:0]        up;
    lo = '0;
    hi = '0;
    case (m)
      2'd0: lo = av * bv;
      2'd1: lo = av * bv + accv;
      2'd2: begin
        up = {32'd0, av} * {32'd0, bv};
        {hi, lo} = up;
      end
      default: begin
        sp = $signed({{32{av[31]}}, av}) * $signed({{32{bv[31]}}, bv});
        {hi, lo} = sp;
      end
    endcase
    if (m[1]) fl = {hi[31], ({hi, lo} == 64'd0)};
    else      fl = {lo[31], (lo == 32'd0)};
  endfunction

  task automatic do_op(input logic [1:0] m, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] accv, input bit glitch, input string tag);
    logic [31:0] elo, ehi;
    logic [1:0]  efl;
    int          n;
    model(m, av, bv, accv, elo, ehi, efl);
    @(negedge clk);
    reset = 1'b0; bus.start = 1'b1; bus.mode = m; bus.a = av; bus.b = bv; bus.acc = accv;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.mode = 2'($urandom); bus.a = $urandom; bus.b = $urandom; bus.acc = $urandom;
    chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
    n = 1;
    while (bus.done !== 1'b1 && n < 100) begin
      if (n == 10) begin
        chk({tag, "_hold_lo"}, 64'(bus.result_lo), 64'(prev_lo));
        chk({tag, "_hold_hi"}, 64'(bus.result_hi), 64'(prev_hi));
      end
      if (glitch && (n == 5 || n == 20)) bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd34);
    chk({tag, "_lo"}, 64'(bus.result_lo), 64'(elo));
    chk({tag, "_hi"}, 64'(bus.result_hi), 64'(ehi));
    chk({tag, "_flags"}, 64'(bus.flags), 64'(efl));
    prev_lo = elo;
    prev_hi = ehi;
    @(posedge clk); #1;
    chk({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_idle_done"}, 64'(bus.done), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int ndone;
    vectors = 0; miscompares = 0;
    prev_lo = '0; prev_hi = '0;
    reset = 1'b1;
    bus.start = 1'b0; bus.mode = 2'd0; bus.a = '0; bus.b = '0; bus.acc = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  64'(bus.busy), 64'd0);
    chk("rst_done",  64'(bus.done), 64'd0);
    chk("rst_lo",    64'(bus.result_lo), 64'd0);
    chk("rst_hi",    64'(bus.result_hi), 64'd0);
    chk("rst_flags", 64'(bus.flags), 64'd0);

    // First op starts on the very edge reset drops.
    do_op(2'd0, 32'd7, 32'd6, 32'd0, 1'b0, "mul_7x6");
    chk("mul_7x6_const", 64'(bus.result_lo), 64'd42);
    chk("mul_7x6_flags_const", 64'(bus.flags), 64'd0);

    do_op(2'd1, 32'd3, 32'd4, 32'd5, 1'b0, "mla_3_4_5");
    chk("mla_const", 64'(bus.result_lo), 64'd17);

    do_op(2'd1, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, "mla_wrap");
    chk("mla_wrap_const", {32'(bus.flags), bus.result_lo}, {32'd1, 32'd0});

    do_op(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, "umull_max");
    chk("umull_const", {bus.result_hi, bus.result_lo}, 64'hFFFF_FFFE_0000_0001);

    do_op(2'd3, 32'hFFFF_FFFE, 32'd3, 32'd0, 1'b0, "smull_m2x3");
    chk("smull_const", {bus.result_hi, bus.result_lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("smull_flags_const", 64'(bus.flags), 64'd2);

    do_op(2'd3, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b0, "smull_min");
    chk("smull_min_const", {bus.result_hi, bus.result_lo}, 64'h4000_0000_0000_0000);

    // Start pulses mid-flight must be ignored.
    do_op(2'd0, 32'd1234, 32'd5678, 32'd0, 1'b1, "mul_glitch");
    chk("mul_glitch_const", 64'(bus.result_lo), 64'd7006652);

    // Abort a UMULL at cycle 10.
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 2'd2; bus.a = 32'hDEAD_BEEF; bus.b = 32'h1234_5678;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy",  64'(bus.busy), 64'd0);
    chk("abort_done",  64'(bus.done), 64'd0);
    chk("abort_lo",    64'(bus.result_lo), 64'd0);
    chk("abort_hi",    64'(bus.result_hi), 64'd0);
    chk("abort_flags", 64'(bus.flags), 64'd0);
    reset = 1'b0;
    prev_lo = '0; prev_hi = '0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);
    do_op(2'd0, 32'd2, 32'd2, 32'd0, 1'b0, "mul_after_abort");
    chk("mul_after_abort_const", 64'(bus.result_lo), 64'd4);

    // Randomized back-to-back operations.
    for (int i = 0; i < 24; i++) begin
      do_op(2'($urandom_range(0, 3)), pick(), pick(), $urandom,
            ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mul_unit.md
MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits; legal values are 8 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 The block SHALL have port mode, input, 2 bits: 00 MUL, 01 MLA, 10 UMULL, 11 SMULL; sampled with start.
REQ-006 The block SHALL have ports a and b, inputs, WIDTH bits each: the multiplicand and multiplier, sampled with start.
REQ-007 The block SHALL have port acc, input, WIDTH bits: the MLA addend, sampled with start and ignored in other modes.
REQ-008 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: a single-cycle pulse marking the result valid.
REQ-010 The block SHALL have port result_lo, output, WIDTH bits: the low half of the result.
REQ-011 The block SHALL have port result_hi, output, WIDTH bits: the high half; 0 in MUL and MLA modes.
REQ-012 The block SHALL have port flags, output, 2 bits: {N,Z} of the result, for the controller's MULS-style flag update.

Function
REQ-013 The block SHALL implement the states IDLE, CALC, FIX and DONE.
REQ-014 The block SHALL move from IDLE to CALC, on an edge where start=1, while latching mode, a, b and acc and clearing the bit counter and the 2*WIDTH partial product.
REQ-015 In SMULL mode the block SHALL latch |a| and |b| and record sign = a[WIDTH-1] XOR b[WIDTH-1]; in all other modes it SHALL treat the operands as unsigned.
REQ-016 In CALC the block SHALL perform one shift-add step per cycle (radix-2, LSB of multiplier first) and leave CALC for FIX after exactly WIDTH steps.
REQ-017 In FIX the block SHALL form the final result in one cycle: SMULL with sign=1 takes the two's-complement negation of the 2*WIDTH product; MLA takes the product low half plus acc, modulo 2^WIDTH; MUL truncates to WIDTH.
REQ-018 The block SHALL go from FIX to DONE, registering result_lo, result_hi and flags on that same edge.
REQ-019 The block SHALL hold done=1 only while in DONE, then return to IDLE on the next edge.
REQ-020 Latency SHALL be fixed: done is high in cycle WIDTH+2 after the start-sampling edge, independent of operand values (no early termination).
REQ-021 The block SHALL hold result_lo, result_hi and flags stable from DONE until the FIX edge of the next operation.
REQ-022 The block SHALL ignore start while busy=1: no queuing, and no effect on the operation in flight.
REQ-023 The block SHALL accept start=1 in the cycle after DONE (IDLE), giving a back-to-back throughput of one operation per WIDTH+3 cycles.
REQ-024 For MUL and MLA, N SHALL be result_lo[WIDTH-1] and Z SHALL be (result_lo==0).
REQ-025 For UMULL and SMULL, N SHALL be result_hi[WIDTH-1] and Z SHALL be ({result_hi,result_lo}==0).
REQ-026 SMULL with an operand equal to the most negative value SHALL produce the exact result; |x| is computed as an unsigned WIDTH-bit value.
REQ-027 Arithmetic wrap SHALL be silent: the block has no overflow or carry output.

Reset
REQ-028 On an edge where reset=1, the block SHALL enter IDLE and set busy=0, done=0, result_lo=0, result_hi=0, flags=0 and the counter to 0.
REQ-029 Reset SHALL take priority over start and over any in-flight state; an aborted operation SHALL produce no done pulse.
REQ-030 The first start SHALL be honoured on the first edge at which reset=0.

Verification (WIDTH=32)
REQ-031 The bench SHALL cover: MUL, a=7, b=6 -> done in cycle 34; result_lo=42, result_hi=0, flags=00.
REQ-032 The bench SHALL cover: MLA, a=3, b=4, acc=5 -> result_lo=17; then MLA a=0xFFFFFFFF, b=1, acc=1 -> result_lo=0, flags=01.
REQ-033 The bench SHALL cover: UMULL, a=b=0xFFFFFFFF -> result_hi=0xFFFFFFFE, result_lo=0x00000001, flags=00.
REQ-034 The bench SHALL cover: SMULL, a=-2, b=3 -> {hi,lo}=0xFFFFFFFF_FFFFFFFA, flags=10; then SMULL a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0.
REQ-035 The bench SHALL cover: start pulsed again at cycles 5 and 20 of an operation -> the original result is unchanged, exactly one done pulse, busy low the cycle after done.
REQ-036 The bench SHALL cover: reset asserted at cycle 10 of a UMULL -> next cycle busy=0 and all outputs 0, no done pulse; a new MUL 2*2 then returns 4 with normal latency.
